// File: rtl/game_screen_ctl.sv
// rtl/game_screen_ctl.sv - frame-synchronous menu/countdown/play/game-over sequencer
// Screen changes commit only on the vblank rising edge so draw stages never switch mid-frame.
module game_screen_ctl #(
  parameter int LIVES            = 3,
  parameter int COUNTDOWN_FRAMES = 120,
  parameter int GAMEOVER_FRAMES  = 180
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        start,
  input  logic        hit,
  output logic [1:0]  mode,
  output logic        mode_chg,
  output logic [2:0]  lives,
  output logic [7:0]  timer,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    S_MENU      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_PLAY      = 2'd2,
    S_GAMEOVER  = 2'd3
  } state_t;

  localparam logic [7:0] CD_LOAD    = 8'(COUNTDOWN_FRAMES - 1);
  localparam logic [7:0] GO_LOAD    = 8'(GAMEOVER_FRAMES - 1);
  localparam logic [2:0] LIVES_LOAD = 3'(LIVES);

  state_t      state_q, state_d;
  logic        vblnk_d, start_d;
  logic        start_req, start_req_d;
  logic        hit_req, hit_req_d;
  logic        mode_chg_q, mode_chg_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  timer_q, timer_d;
  logic [15:0] frame_q, frame_d;
  logic        tick, start_edge, start_eff, hit_eff;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      // Delay registers reset high so levels already asserted at release are not edges.
      vblnk_d    <= 1'b1;
      start_d    <= 1'b1;
      start_req  <= 1'b0;
      hit_req    <= 1'b0;
      state_q    <= S_MENU;
      mode_chg_q <= 1'b0;
      lives_q    <= 3'd0;
      timer_q    <= 8'd0;
      frame_q    <= 16'd0;
    end else begin
      vblnk_d    <= vblnk_in;
      start_d    <= start;
      start_req  <= start_req_d;
      hit_req    <= hit_req_d;
      state_q    <= state_d;
      mode_chg_q <= mode_chg_d;
      lives_q    <= lives_d;
      timer_q    <= timer_d;
      frame_q    <= frame_d;
    end
  end

  always_comb begin
    tick        = vblnk_in & ~vblnk_d;
    start_edge  = start & ~start_d;
    start_eff   = start_req | start_edge;
    hit_eff     = hit_req | hit;
    start_req_d = tick ? 1'b0 : start_eff;
    hit_req_d   = tick ? 1'b0 : hit_eff;
    state_d     = state_q;
    lives_d     = lives_q;
    timer_d     = timer_q;
    frame_d     = frame_q;
    mode_chg_d  = 1'b0;

    if (tick) begin
      case (state_q)
        S_MENU: begin
          if (start_eff) begin
            state_d = S_COUNTDOWN;
            timer_d = CD_LOAD;
            lives_d = LIVES_LOAD;
            frame_d = 16'd0;
          end
        end
        S_COUNTDOWN: begin
          if (timer_q == 8'd0) begin
            state_d = S_PLAY;
            frame_d = 16'd0;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        S_PLAY: begin
          if (hit_eff && lives_q <= 3'd1) begin
            // Final hit keeps the pre-tick frame count on display.
            state_d = S_GAMEOVER;
            lives_d = 3'd0;
            timer_d = GO_LOAD;
          end else begin
            frame_d = (frame_q == 16'hFFFF) ? frame_q : frame_q + 16'd1;
            if (hit_eff) lives_d = lives_q - 3'd1;
          end
        end
        S_GAMEOVER: begin
          if (timer_q == 8'd0) begin
            state_d = S_MENU;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        default: state_d = S_MENU;
      endcase
      if (state_d == S_MENU || state_d == S_PLAY) timer_d = 8'd0;
      mode_chg_d = (state_d != state_q);
    end
  end

  assign mode      = state_q;
  assign mode_chg  = mode_chg_q;
  assign lives     = lives_q;
  assign timer     = timer_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_game_screen_ctl.sv
// tb/tb_game_screen_ctl.sv - directed self-checking bench for game_screen_ctl
// Inputs change and outputs are sampled on the falling edge of pclk.
module tb_game_screen_ctl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vblnk_in;
  logic        start;
  logic        hit;
  logic [1:0]  mode;
  logic        mode_chg;
  logic [2:0]  lives;
  logic [7:0]  timer;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  game_screen_ctl #(
    .LIVES(2),
    .COUNTDOWN_FRAMES(2),
    .GAMEOVER_FRAMES(3)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .vblnk_in(vblnk_in),
    .start(start),
    .hit(hit),
    .mode(mode),
    .mode_chg(mode_chg),
    .lives(lives),
    .timer(timer),
    .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic end_frame();
    vblnk_in = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic do_tick();
    vblnk_in = 1'b1;
    cyc();
  endtask

  task automatic check_all(input string tag, input logic [1:0] m, input logic [2:0] l,
                           input logic [7:0] t, input logic [15:0] f);
    check({tag, ".mode"}, 32'(mode), 32'(m));
    check({tag, ".lives"}, 32'(lives), 32'(l));
    check({tag, ".timer"}, 32'(timer), 32'(t));
    check({tag, ".frame"}, 32'(frame_cnt), 32'(f));
  endtask

  initial begin
    rst = 1'b0; vblnk_in = 1'b1; start = 1'b1; hit = 1'b0;
    cyc();
    cyc();
    check_all("reset", 2'd0, 3'd0, 8'd0, 16'd0);
    check("reset.mode_chg", 32'(mode_chg), 32'd0);
    rst = 1'b1;
    cyc();
    check("release_no_tick", 32'(mode), 32'd0);
    for (int i = 0; i < 3; i++) begin
      end_frame();
      do_tick();
      check("start_held", 32'(mode), 32'd0);
    end

    start = 1'b0; cyc();
    start = 1'b1; cyc();
    start = 1'b0;
    end_frame();
    do_tick();
    check_all("to_countdown", 2'd1, 3'd2, 8'd1, 16'd0);
    check("chg_high", 32'(mode_chg), 32'd1);
    cyc();
    check("chg_one_cycle", 32'(mode_chg), 32'd0);

    end_frame(); do_tick();
    check_all("countdown_t0", 2'd1, 3'd2, 8'd0, 16'd0);
    end_frame(); do_tick();
    check_all("to_play", 2'd2, 3'd2, 8'd0, 16'd0);
    check("to_play.chg", 32'(mode_chg), 32'd1);

    end_frame();
    for (int i = 0; i < 3; i++) begin
      hit = 1'b1; cyc();
      hit = 1'b0; cyc();
    end
    do_tick();
    check_all("multi_hit", 2'd2, 3'd1, 8'd0, 16'd1);
    end_frame(); do_tick();
    check_all("play_quiet", 2'd2, 3'd1, 8'd0, 16'd2);
    end_frame();
    hit = 1'b1; cyc();
    hit = 1'b0;
    do_tick();
    check_all("to_gameover", 2'd3, 3'd0, 8'd2, 16'd2);
    check("to_gameover.chg", 32'(mode_chg), 32'd1);

    for (int i = 1; i >= 0; i--) begin
      end_frame();
      start = 1'b1; cyc();
      start = 1'b0;
      do_tick();
      check_all("gameover_hold", 2'd3, 3'd0, 8'(i), 16'd2);
    end
    end_frame();
    start = 1'b1; cyc();
    start = 1'b0;
    do_tick();
    check_all("to_menu", 2'd0, 3'd0, 8'd0, 16'd2);
    check("to_menu.chg", 32'(mode_chg), 32'd1);
    end_frame(); do_tick();
    check("no_autorestart", 32'(mode), 32'd0);

    end_frame();
    start = 1'b1; cyc();
    check("midframe_hold1", 32'(mode), 32'd0);
    start = 1'b0; cyc();
    check("midframe_hold2", 32'(mode), 32'd0);
    do_tick();
    check_all("midframe_start", 2'd1, 3'd2, 8'd1, 16'd0);

    end_frame(); do_tick();
    end_frame(); do_tick();
    check("play_again", 32'(mode), 32'd2);

    end_frame();
    hit = 1'b1;
    do_tick();
    hit = 1'b0;
    check_all("hit_on_tick", 2'd2, 3'd1, 8'd0, 16'd1);

    end_frame();
    force dut.frame_q = 16'hFFFE;
    #1;
    release dut.frame_q;
    do_tick();
    check_all("sat_ffff", 2'd2, 3'd1, 8'd0, 16'hFFFF);
    end_frame(); do_tick();
    check("sat_hold", 32'(frame_cnt), 32'hFFFF);

    end_frame();
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 2'd0, 3'd0, 8'd0, 16'd0);
    check("async_rst.chg", 32'(mode_chg), 32'd0);
    @(negedge pclk);
    rst = 1'b1;
    cyc();

    end_frame();
    start = 1'b1;
    do_tick();
    start = 1'b0;
    check_all("start_on_tick", 2'd1, 3'd2, 8'd1, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
